// File: rtl/fetch_redirect_unit_if.sv
// Fetch front-end bus bundle.
// Groups the branch-redirect controls, the instruction-memory address/data
// pair and the IF/ID register outputs of fetch_redirect_unit.
//   master : the fetch unit (drives imem_addr and the IF/ID/status outputs)
//   slave  : the surrounding pipeline / memory model (drives controls, imem_data)
interface fetch_redirect_unit_if #(
    parameter int CNT_W = 16
);
    logic              stall;
    logic              taken;
    logic              flush;
    logic [15:0]       target_address;
    logic [15:0]       imem_addr;
    logic [31:0]       imem_data;
    logic [31:0]       ifid_instr;
    logic [15:0]       ifid_pc;
    logic              ifid_valid;
    logic              halted;
    logic [CNT_W-1:0]  redirect_count;

    modport master (
        input  stall, taken, flush, target_address, imem_data,
        output imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, redirect_count
    );

    modport slave (
        output stall, taken, flush, target_address, imem_data,
        input  imem_addr, ifid_instr, ifid_pc, ifid_valid, halted, redirect_count
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end.
// Owns the PC, presents it as the instruction-memory address, and registers
// the fetched word into IF/ID one cycle later. A resolved taken branch loads
// the target and squashes IF/ID; flush alone only squashes. Stall freezes
// PC and IF/ID. Fetching HALT_WORD parks the PC until a taken redirect.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : fetch_redirect_unit_if.master
//            in : stall, taken, flush, target_address, imem_data
//            out: imem_addr, ifid_instr, ifid_pc, ifid_valid, halted,
//                 redirect_count (saturating count of taken redirects)
module fetch_redirect_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] PC_STEP   = 16'd4,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_redirect_unit_if.master bus
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    logic [15:0]       pc_p0;
    logic [31:0]       instr_p1;
    logic [15:0]       pc_p1;
    logic              vld_p1;
    logic [CNT_W-1:0]  redir_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // IF stage: PC drives the memory address directly
    assign bus.imem_addr = pc_p0;

    // IF/ID boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            pc_p0     <= RESET_PC;
            instr_p1  <= '0;
            pc_p1     <= '0;
            vld_p1    <= 1'b0;
            redir_cnt <= '0;
        end else if (bus.taken) begin
            // Redirect wins over stall and halt; IF/ID data is left stale
            // because the cleared valid bit already marks it dead.
            pc_p0     <= bus.target_address;
            vld_p1    <= 1'b0;
            state     <= RUN;
            redir_cnt <= sat_inc(redir_cnt);
        end else if (bus.stall) begin
            if (bus.flush) begin
                vld_p1 <= 1'b0;
            end
        end else if (state == HALTED) begin
            // The halt word was presented on the previous edge; never repeat it.
            vld_p1 <= 1'b0;
        end else begin
            instr_p1 <= bus.imem_data;
            pc_p1    <= pc_p0;
            vld_p1   <= !bus.flush;
            if (bus.imem_data == HALT_WORD) begin
                state <= HALTED;
            end else begin
                pc_p0 <= pc_p0 + PC_STEP;
            end
        end
    end

    assign bus.ifid_instr     = instr_p1;
    assign bus.ifid_pc        = pc_p1;
    assign bus.ifid_valid     = vld_p1;
    assign bus.halted         = (state == HALTED);
    assign bus.redirect_count = redir_cnt;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] halt_addr;

    fetch_redirect_unit_if #(.CNT_W(16)) bus ();

    fetch_redirect_unit #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'd4),
        .HALT_WORD(HALT_WORD),
        .CNT_W    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Memory image: every word is 0x1111_0000 + address, except one halt slot.
    function automatic logic [31:0] mem_word(input logic [15:0] a, input logic [15:0] h);
        return (a == h) ? HALT_WORD : (32'h1111_0000 + {16'h0, a});
    endfunction

    always_comb bus.imem_data = mem_word(bus.imem_addr, halt_addr);

    int tests = 0;
    int fails = 0;

    // Reference state of the fetch front end
    logic [15:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_ifpc;
    logic        m_vld;
    logic        m_halt;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the reference, compare all outputs.
    task automatic step(input logic rst_i, input logic st, input logic tk,
                        input logic fl, input logic [15:0] tgt);
        logic [31:0] w;
        @(negedge clk);
        reset              = rst_i;
        bus.stall          = st;
        bus.taken          = tk;
        bus.flush          = fl;
        bus.target_address = tgt;
        @(posedge clk);
        if (rst_i) begin
            m_pc = 16'h0000; m_instr = '0; m_ifpc = '0; m_vld = 1'b0;
            m_halt = 1'b0; m_cnt = 0;
        end else if (tk) begin
            m_pc   = tgt;
            m_vld  = 1'b0;
            m_halt = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (st) begin
            if (fl) m_vld = 1'b0;
        end else if (m_halt) begin
            m_vld = 1'b0;
        end else begin
            w       = mem_word(m_pc, halt_addr);
            m_instr = w;
            m_ifpc  = m_pc;
            m_vld   = !fl;
            if (w == HALT_WORD) m_halt = 1'b1;
            else                m_pc   = 16'((32'(m_pc) + 4) % 65536);
        end
        #1;
        chk("imem_addr",      {16'h0, bus.imem_addr},      {16'h0, m_pc});
        chk("ifid_valid",     {31'h0, bus.ifid_valid},     {31'h0, m_vld});
        chk("ifid_instr",     bus.ifid_instr,              m_instr);
        chk("ifid_pc",        {16'h0, bus.ifid_pc},        {16'h0, m_ifpc});
        chk("halted",         {31'h0, bus.halted},         {31'h0, m_halt});
        chk("redirect_count", {16'h0, bus.redirect_count}, 32'(m_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        halt_addr = 16'h0020;
        reset = 1'b1; bus.stall = 1'b0; bus.taken = 1'b0; bus.flush = 1'b0;
        bus.target_address = 16'h0;
        m_pc = '0; m_instr = '0; m_ifpc = '0; m_vld = 1'b0; m_halt = 1'b0; m_cnt = 0;

        // Reset
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst_addr",  {16'h0, bus.imem_addr}, 32'h0);
        chk("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);

        // Sequential fetch 0,4,8
        run(1); chk("seq_pc0", {16'h0, bus.ifid_pc}, 32'h0);
        run(1); chk("seq_pc4", {16'h0, bus.ifid_pc}, 32'h4);
        run(1); chk("seq_pc8", {16'h0, bus.ifid_pc}, 32'h8);
        chk("seq_instr", bus.ifid_instr, 32'h1111_0008);
        chk("seq_addrC", {16'h0, bus.imem_addr}, 32'hC);

        // Stall holds PC=0xC, then stall+taken redirects anyway
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        chk("stall_addr", {16'h0, bus.imem_addr}, 32'hC);
        chk("stall_ifpc", {16'h0, bus.ifid_pc}, 32'h8);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
        chk("stk_addr",  {16'h0, bus.imem_addr}, 32'h100);
        chk("stk_valid", {31'h0, bus.ifid_valid}, 32'h0);

        // Taken+flush to 0x40
        run(1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0040);
        chk("redir_addr", {16'h0, bus.imem_addr}, 32'h40);
        chk("redir_cnt",  {16'h0, bus.redirect_count}, 32'd2);
        run(1);
        chk("redir_ifpc", {16'h0, bus.ifid_pc}, 32'h40);

        // PC wrap
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFC);
        chk("wrap_a", {16'h0, bus.imem_addr}, 32'hFFFC);
        run(1);
        chk("wrap_b", {16'h0, bus.imem_addr}, 32'h0000);

        // Halt at 0x20 then resume at 0x80
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0018);
        run(3);
        chk("halt_flag", {31'h0, bus.halted}, 32'h1);
        chk("halt_ifpc", {16'h0, bus.ifid_pc}, 32'h20);
        chk("halt_vld",  {31'h0, bus.ifid_valid}, 32'h1);
        run(2);
        chk("halt_hold", {16'h0, bus.imem_addr}, 32'h20);
        chk("halt_once", {31'h0, bus.ifid_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0080);
        chk("resume_h", {31'h0, bus.halted}, 32'h0);
        chk("resume_a", {16'h0, bus.imem_addr}, 32'h80);

        // Halt again with count 6, then reset
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'h001C);
        run(3);
        chk("halt2_flag", {31'h0, bus.halted}, 32'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("rst2_addr", {16'h0, bus.imem_addr}, 32'h0);
        chk("rst2_halt", {31'h0, bus.halted}, 32'h0);
        chk("rst2_cnt",  {16'h0, bus.redirect_count}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, t, f;
            logic [15:0] tg;
            r  = ($urandom_range(0, 99) < 2);
            s  = ($urandom_range(0, 99) < 25);
            t  = ($urandom_range(0, 99) < 10);
            f  = t ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 99) < 5);
            tg = ($urandom_range(0, 9) == 0) ? 16'hFFF8 : 16'(($urandom_range(0, 15)) * 4);
            step(r, s, t, f, tg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
